// File: rtl/nlfsr_coef_feeder_if.sv
// Coefficient-load and result bus between the coefficient feeder (master side)
// and the NLFSR / search controller (slave side).
interface nlfsr_coef_feeder_if #(
  parameter int NUM_OF_TAPS = 2
);
  logic                     start;
  logic                     ready;
  logic                     found;
  logic                     failure;
  logic                     ena;
  logic                     take_coef;
  logic [7:0]               coef;
  logic                     busy;
  logic                     done;
  logic                     hit_valid;
  logic [NUM_OF_TAPS*8-1:0] hit_taps;
  logic [15:0]              hit_count;
  logic                     timeout_err;

  modport master (
    input  start, ready, found, failure,
    output ena, take_coef, coef, busy, done, hit_valid, hit_taps, hit_count, timeout_err
  );

  modport slave (
    output start, ready, found, failure,
    input  ena, take_coef, coef, busy, done, hit_valid, hit_taps, hit_count, timeout_err
  );
endinterface

// File: rtl/nlfsr_coef_feeder.sv
// Enumerates every strictly ascending tap tuple, streams it byte-serially into
// one NLFSR and collects the tuples the NLFSR reports as found.
module nlfsr_coef_feeder #(
  parameter int BYTES       = 4,
  parameter int NUM_OF_TAPS = 2,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                res,
  nlfsr_coef_feeder_if.master bus
);
  localparam int MAX_TAP = BYTES * 8 - 2;
  localparam int IDX_W   = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef logic [NUM_OF_TAPS-1:0][7:0] tuple_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SEND, S_GAP, S_WAIT_RES, S_REPORT, S_NEXT, S_DONE
  } state_e;

  function automatic tuple_t first_tuple();
    tuple_t t;
    for (int i = 0; i < NUM_OF_TAPS; i++) t[i] = 8'(i + 1);
    return t;
  endfunction

  localparam tuple_t FIRST_TUPLE = first_tuple();

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  tuple_t           tap_q, tap_d;
  logic [7:0]       coef_q, coef_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  tuple_t           hit_taps_q, hit_taps_d;
  logic [15:0]      hit_count_q, hit_count_d;
  logic             timeout_q, timeout_d;

  logic             adv_found;
  logic [IDX_W-1:0] adv_pos;
  tuple_t           tap_adv;

  // Odometer step: bump the rightmost tap that still has headroom, then pack
  // every tap to its right directly behind it.
  always_comb begin
    adv_found = 1'b0;
    adv_pos   = '0;
    for (int i = 0; i < NUM_OF_TAPS; i++) begin
      if (tap_q[i] < 8'(MAX_TAP - (NUM_OF_TAPS - 1 - i))) begin
        adv_found = 1'b1;
        adv_pos   = IDX_W'(i);
      end
    end
    tap_adv    = tap_q;
    tap_adv[0] = (adv_found && adv_pos == '0) ? tap_q[0] + 8'd1 : tap_q[0];
    for (int j = 1; j < NUM_OF_TAPS; j++) begin
      if (adv_found && IDX_W'(j) == adv_pos) tap_adv[j] = tap_q[j] + 8'd1;
      else if (adv_found && IDX_W'(j) > adv_pos) tap_adv[j] = tap_adv[j-1] + 8'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tap_d       = tap_q;
    coef_d      = coef_q;
    gap_cnt_d   = gap_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    hit_taps_d  = hit_taps_q;
    hit_count_d = hit_count_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_WAIT_RDY;
          idx_d       = '0;
          tap_d       = FIRST_TUPLE;
          hit_count_d = '0;
          timeout_d   = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (bus.ready) begin
          state_d = S_SEND;
          coef_d  = tap_q[idx_q];
        end
      end
      S_SEND: begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          if (idx_q < IDX_W'(NUM_OF_TAPS - 1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_WAIT_RDY;
          end else begin
            state_d    = S_WAIT_RES;
            wait_cnt_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_WAIT_RES: begin
        if (bus.found) begin
          state_d    = S_REPORT;
          hit_taps_d = tap_q;
          if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
        end else if (bus.failure) begin
          state_d = S_NEXT;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = S_NEXT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_REPORT: state_d = S_NEXT;
      S_NEXT: begin
        if (adv_found) begin
          tap_d   = tap_adv;
          idx_d   = '0;
          state_d = S_WAIT_RDY;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tap_q       <= FIRST_TUPLE;
      coef_q      <= '0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      hit_taps_q  <= '0;
      hit_count_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tap_q       <= tap_d;
      coef_q      <= coef_d;
      gap_cnt_q   <= gap_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      hit_taps_q  <= hit_taps_d;
      hit_count_q <= hit_count_d;
      timeout_q   <= timeout_d;
    end
  end

  // Strobes decode straight from the state so reset forces them low at once.
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.ena         = bus.busy && (state_q != S_NEXT);
  assign bus.take_coef   = (state_q == S_SEND);
  assign bus.hit_valid   = (state_q == S_REPORT);
  assign bus.coef        = coef_q;
  assign bus.hit_taps    = hit_taps_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_nlfsr_coef_feeder.sv
// Directed bench for nlfsr_coef_feeder: a small NLFSR responder model plus
// scenario tasks with hand-computed expectations.
module tb_nlfsr_coef_feeder;
  logic clk;
  logic res;
  int   cyc;
  int   checks   = 0;
  int   failures = 0;

  nlfsr_coef_feeder_if #(.NUM_OF_TAPS(2)) bus ();

  nlfsr_coef_feeder #(
    .BYTES(4), .NUM_OF_TAPS(2), .GAP_CYC(8), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Responder model state: 0 = silent, 1 = fail unless tuple == target,
  // 2 = drive found and failure together on target.
  int          resp_mode = 1;
  logic [15:0] target    = 16'h1207;

  logic [7:0]  coef_log[$];
  int          stamp_log[$];
  int          hits          = 0;
  logic [15:0] last_hit      = '0;
  int          tuples_sent   = 0;
  logic [15:0] last_tuple    = '0;
  int          ena_low_total = 0;
  int          run_max       = 0;

  initial begin : nlfsr_model
    logic [7:0] cur0;
    int nb;
    int vdelay;
    int run;
    cur0 = '0; nb = 0; vdelay = 0; run = 0;
    bus.found   = 1'b0;
    bus.failure = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy && !bus.ena) begin
        run++;
        ena_low_total++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
      if (bus.hit_valid) begin
        hits++;
        last_hit = bus.hit_taps;
      end
      if (!bus.ena) begin
        nb = 0; vdelay = 0;
        bus.found   = 1'b0;
        bus.failure = 1'b0;
      end else if (bus.take_coef) begin
        coef_log.push_back(bus.coef);
        stamp_log.push_back(cyc);
        if (nb == 0) begin
          cur0 = bus.coef;
          nb   = 1;
        end else begin
          last_tuple = {bus.coef, cur0};
          tuples_sent++;
          nb     = 0;
          vdelay = 2;
        end
      end else if (vdelay > 0) begin
        vdelay--;
        if (vdelay == 0 && resp_mode != 0) begin
          if (last_tuple == target) begin
            bus.found   = 1'b1;
            bus.failure = (resp_mode == 2);
          end else begin
            bus.failure = 1'b1;
          end
        end
      end
    end
  end

  task automatic hold_reset();
    bus.start = 1'b0;
    res       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    res = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1 bus.start = 1'b1;
    @(negedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k = 0;
    while (coef_log.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (coef_log.size() < n) begin
      failures++;
      $display("FAIL %s: take_coef pulses=%0d, wanted %0d", tag, coef_log.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.ready = 1'b0;
    hold_reset();
    checks++;
    if ({bus.ena, bus.take_coef, bus.busy, bus.done, bus.hit_valid, bus.timeout_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: ena,take,busy,done,hit,to=%b expected 000000",
               {bus.ena, bus.take_coef, bus.busy, bus.done, bus.hit_valid, bus.timeout_err});
    end
    checks++;
    if (bus.coef !== 8'h00) begin
      failures++; $display("FAIL reset_coef: got %h expected 00", bus.coef);
    end
    checks++;
    if (bus.hit_taps !== 16'h0000 || bus.hit_count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hits: taps=%h count=%h expected 0000/0000", bus.hit_taps, bus.hit_count);
    end
    release_reset();
  endtask

  task automatic test_full_run();
    int b, h0, t0, l0, k;
    resp_mode = 1;
    target    = 16'h1207;
    bus.ready = 1'b1;
    b  = coef_log.size();
    h0 = hits;
    t0 = tuples_sent;
    l0 = ena_low_total;
    pulse_start();
    k = 0;
    while (!bus.done && k < 12000) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++; $display("FAIL full_done_timeout: done=%b after %0d cycles", bus.done, k);
    end
    // First two tuples: bytes, pulse spacing and the single ena-low cycle.
    checks++;
    if (coef_log[b] !== 8'h01 || coef_log[b+1] !== 8'h02 || coef_log[b+2] !== 8'h01 ||
        coef_log[b+3] !== 8'h03) begin
      failures++;
      $display("FAIL first_coefs: got %h %h %h %h expected 01 02 01 03",
               coef_log[b], coef_log[b+1], coef_log[b+2], coef_log[b+3]);
    end
    checks++;
    if (stamp_log[b+1] - stamp_log[b] !== 10) begin
      failures++; $display("FAIL pulse_spacing: got %0d expected 10", stamp_log[b+1] - stamp_log[b]);
    end
    checks++;
    if (stamp_log[b+2] - stamp_log[b+1] !== 12) begin
      failures++;
      $display("FAIL tuple_turnaround: got %0d expected 12", stamp_log[b+2] - stamp_log[b+1]);
    end
    checks++;
    if (run_max !== 1 || ena_low_total - l0 !== 435) begin
      failures++;
      $display("FAIL ena_low: max run %0d total %0d expected 1 and 435", run_max, ena_low_total - l0);
    end
    checks++;
    if (tuples_sent - t0 !== 435) begin
      failures++; $display("FAIL tuple_count: got %0d expected 435", tuples_sent - t0);
    end
    checks++;
    if (last_tuple !== 16'h1E1D) begin
      failures++; $display("FAIL last_tuple: got %h expected 1e1d", last_tuple);
    end
    checks++;
    if (hits - h0 !== 1 || last_hit !== 16'h1207) begin
      failures++;
      $display("FAIL hit_pulse: pulses %0d taps %h expected 1 and 1207", hits - h0, last_hit);
    end
    checks++;
    if (bus.hit_count !== 16'd1 || bus.hit_taps !== 16'h1207) begin
      failures++;
      $display("FAIL hit_regs: count %h taps %h expected 0001 1207", bus.hit_count, bus.hit_taps);
    end
    checks++;
    if ({bus.done, bus.busy, bus.ena} !== 3'b100) begin
      failures++;
      $display("FAIL done_state: done,busy,ena=%b expected 100", {bus.done, bus.busy, bus.ena});
    end
  endtask

  task automatic test_restart();
    pulse_start();
    checks++;
    if (bus.hit_count !== 16'd0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: count %h done %b expected 0000 0", bus.hit_count, bus.done);
    end
    checks++;
    if ({bus.busy, bus.ena} !== 2'b11) begin
      failures++; $display("FAIL restart_run: busy,ena=%b expected 11", {bus.busy, bus.ena});
    end
    hold_reset();
    release_reset();
  endtask

  task automatic test_ready_low();
    int b;
    bus.ready = 1'b0;
    b = coef_log.size();
    pulse_start();
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (coef_log.size() !== b || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL ready_hold: pulses %0d busy %b expected 0 and 1", coef_log.size() - b, bus.busy);
    end
    bus.ready = 1'b1;
    checks++;
    if (bus.take_coef !== 1'b0) begin
      failures++; $display("FAIL ready_rise_now: take_coef %b expected 0", bus.take_coef);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.take_coef !== 1'b1 || bus.coef !== 8'h01) begin
      failures++;
      $display("FAIL ready_take: take_coef %b coef %h expected 1 01", bus.take_coef, bus.coef);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.take_coef !== 1'b0 || bus.coef !== 8'h01) begin
      failures++;
      $display("FAIL take_one_cycle: take_coef %b coef %h expected 0 01", bus.take_coef, bus.coef);
    end
    hold_reset();
    release_reset();
  endtask

  task automatic test_timeout();
    int b;
    resp_mode = 0;
    bus.ready = 1'b1;
    b = coef_log.size();
    pulse_start();
    wait_pulses(b + 2, 100, "timeout_second_byte");
    repeat (24) @(negedge clk);
    #1;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      failures++; $display("FAIL timeout_early: timeout_err %b expected 0", bus.timeout_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.ena !== 1'b0) begin
      failures++;
      $display("FAIL timeout_set: timeout_err %b ena %b expected 1 0", bus.timeout_err, bus.ena);
    end
    wait_pulses(b + 4, 100, "timeout_continue");
    checks++;
    if (coef_log[b+2] !== 8'h01 || coef_log[b+3] !== 8'h03) begin
      failures++;
      $display("FAIL timeout_next_tuple: got %h %h expected 01 03", coef_log[b+2], coef_log[b+3]);
    end
    checks++;
    if (bus.hit_count !== 16'd0 || bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: count %h timeout_err %b expected 0000 1",
               bus.hit_count, bus.timeout_err);
    end
    hold_reset();
    release_reset();
  endtask

  task automatic test_both_verdicts_and_abort();
    int b, h0;
    resp_mode = 2;
    target    = 16'h0201;
    bus.ready = 1'b1;
    b  = coef_log.size();
    h0 = hits;
    pulse_start();
    wait_pulses(b + 3, 100, "both_second_tuple");
    checks++;
    if (hits - h0 !== 1 || last_hit !== 16'h0201 || bus.hit_count !== 16'd1) begin
      failures++;
      $display("FAIL both_verdicts: pulses %0d taps %h count %h expected 1 0201 0001",
               hits - h0, last_hit, bus.hit_count);
    end
    // Now inside the gap after the first byte of (01,03).
    repeat (3) @(negedge clk);
    #1;
    res = 1'b0;
    #1;
    checks++;
    if ({bus.ena, bus.take_coef, bus.busy, bus.done, bus.hit_valid, bus.timeout_err} !== 6'b0 ||
        bus.coef !== 8'h00) begin
      failures++;
      $display("FAIL abort_flags: flags %b coef %h expected 000000 00",
               {bus.ena, bus.take_coef, bus.busy, bus.done, bus.hit_valid, bus.timeout_err}, bus.coef);
    end
    checks++;
    if (bus.hit_count !== 16'd0 || bus.hit_taps !== 16'h0000) begin
      failures++;
      $display("FAIL abort_hits: count %h taps %h expected 0000 0000", bus.hit_count, bus.hit_taps);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (hits - h0 !== 1) begin
      failures++; $display("FAIL abort_no_hit: pulses %0d expected 1", hits - h0);
    end
    release_reset();
    resp_mode = 1;
    b = coef_log.size();
    pulse_start();
    wait_pulses(b + 2, 100, "restart_after_abort");
    checks++;
    if (coef_log[b] !== 8'h01 || coef_log[b+1] !== 8'h02) begin
      failures++;
      $display("FAIL abort_restart: got %h %h expected 01 02", coef_log[b], coef_log[b+1]);
    end
    hold_reset();
    release_reset();
  endtask

  initial begin
    res       = 1'b0;
    bus.start = 1'b0;
    bus.ready = 1'b0;
    test_reset();
    test_full_run();
    test_restart();
    test_ready_low();
    test_timeout();
    test_both_verdicts_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nlfsr_coef_feeder.md
# nlfsr_coef_feeder

Drives the NLFSR coefficient-load interface from the other side: it enumerates every strictly ascending tuple of `NUM_OF_TAPS` tap positions and sends each tuple byte-serially to the NLFSR over `take_coef`/`coef`. After each tuple it waits for the NLFSR's `found`/`failure` verdict and reports the tuples that were found. It sits between the search controller, which issues `start`, and one NLFSR instance, replacing the hand-driven coefficient stimulus.

## Interface
- `BYTES`, 4: NLFSR length in bytes. Taps range over `MIN_TAP`=1 .. `MAX_TAP`=`BYTES*8-2`.
- `NUM_OF_TAPS`, 2: number of coefficient bytes per tuple.
- `GAP_CYC`, 8: idle cycles after each `take_coef` pulse. Must be at least 1.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT_RES.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `res`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a full enumeration. Sampled only in IDLE.
- `ready`  in  1  NLFSR can accept a coefficient byte.
- `found`  in  1  NLFSR verdict: the current tuple passes.
- `failure`  in  1  NLFSR verdict: the current tuple fails.
- `ena`  out  1  NLFSR enable.
- `take_coef`  out  1  one-cycle strobe; `coef` is valid while it is high.
- `coef`  out  8  coefficient byte.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE. Cleared by `start`.
- `hit_valid`  out  1  one-cycle pulse per found tuple.
- `hit_taps`  out  `NUM_OF_TAPS*8`  found tuple. `tap[i]` is in bits [8i+7:8i].
- `hit_count`  out  16  number of found tuples, saturating at 16'hFFFF.
- `timeout_err`  out  1  sticky flag. Cleared by `start`.

## Operation
- Reset (`res`=0, effective immediately):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Tap registers are loaded with 1, 2, ..., `NUM_OF_TAPS`.
- States: IDLE, WAIT_RDY, SEND, GAP, WAIT_RES, REPORT, NEXT, DONE.
- IDLE, `start`=1:
  - Load the first tuple; set `idx`=0.
  - Clear `hit_count`, `done` and `timeout_err`.
  - Set `ena`=1 and go to WAIT_RDY.
- WAIT_RDY: hold until `ready`=1, then go to SEND.
- SEND (exactly one cycle):
  - `take_coef`=1, `coef`=`tap[idx]`.
  - Go to GAP.
- GAP:
  - `take_coef`=0; `coef` holds its value.
  - Stay `GAP_CYC` cycles.
  - Then: if `idx` < `NUM_OF_TAPS-1`, increment `idx` and go to WAIT_RDY; otherwise go to WAIT_RES.
- WAIT_RES:
  - `found`=1 → REPORT.
  - `failure`=1 (and `found`=0) → NEXT.
  - If both are high in the same cycle, `found` wins.
  - After `TIMEOUT` cycles with neither: set `timeout_err`, treat the tuple as failed, go to NEXT.
  - The cycle counter restarts on every entry.
- REPORT (one cycle):
  - `hit_valid`=1, `hit_taps`=current tuple.
  - Increment `hit_count`.
  - Go to NEXT.
- NEXT (one cycle):
  - `ena`=0, which restarts the NLFSR.
  - Advance the tuple with an odometer rule: find the highest i where `tap[i]` < `MAX_TAP-(NUM_OF_TAPS-1-i)`; increment `tap[i]`; set `tap[j]`=`tap[j-1]+1` for every j > i.
  - If no such i exists (last tuple): go to DONE, `ena` stays 0.
  - Otherwise: `idx`=0, `ena`=1, go to WAIT_RDY.
- DONE:
  - `done`=1, `busy`=0.
  - `start` re-enters the IDLE start behaviour on the next cycle.
- `start` is ignored while `busy`=1.
- `hit_taps` holds its value until the next REPORT.
- Mid-run reset aborts immediately. No `hit_valid` is generated and `hit_count` clears.

## Timing
- `start` sampled at edge N → `ena`=1 from N+1.
- `ready` sampled high at edge M in WAIT_RDY → `take_coef` high during cycle M+1 only.
- `take_coef` pulse spacing, minimum: 1 + `GAP_CYC` + 1 cycles. The WAIT_RDY check costs at least 1 cycle.
- Verdict sampled at edge K:
  - `found` → `hit_valid` in cycle K+1, NEXT at K+2.
  - `failure` → NEXT at K+1.
- `ena` is low for exactly one cycle between consecutive tuples.
- Tuple count: C(`MAX_TAP`, `NUM_OF_TAPS`). With the defaults that is C(30,2)=435.

## Test plan
- Defaults; `ready`=1; `failure` driven 2 cycles after the second `take_coef` → pulses carry `coef` 01, 02, then 01, 03; spacing is `GAP_CYC`+2 cycles; `ena` low for one cycle before the second tuple.
- NLFSR model asserts `found` only for tuple (07,12) → exactly one `hit_valid`, `hit_taps`=16'h1207, `hit_count`=1 at `done`, 435 tuples sent.
- Full run to the end → last tuple sent is (1D,1E); then `done`=1, `busy`=0, `ena`=0; `start` re-runs with `hit_count` cleared.
- `ready` held low 20 cycles in WAIT_RDY → no `take_coef` until `ready` rises; `take_coef` exactly 1 cycle after the rise.
- No verdict ever driven, `TIMEOUT`=16 → `timeout_err`=1 after 16 cycles of WAIT_RES; enumeration continues; `hit_count` stays 0.
- `found` and `failure` both high in one cycle → reported as a hit. `res` pulled low during GAP → all outputs 0 asynchronously; a fresh `start` restarts from (01,02).
